pool2x2_stream: RTL and testbench

Streaming 2x2/stride-2 pooling engine, the sequential successor to the combinational average-pool stage. It consumes a raster-order feature map one pixel per beat, with all DEPTH channels packed per beat, and emits the pooled map in raster order. Pooling mode is selectable per frame: average or max. It sits between a convolution/activation stage and the next layer, and uses valid/ready handshakes on both sides.

---
 rtl/pool2x2_stream.sv | 123 ++++++++++++
 tb/tb_pool2x2_stream.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool2x2_stream.sv
// Streaming 2x2 / stride-2 average-or-max pooling over a raster-order feature map.
// One pixel (DEPTH packed channels) per beat in, one pooled pixel out per 2x2 block.
module pool2x2_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int INPUT_H    = 28,
  parameter int INPUT_W    = 28,
  parameter int DEPTH      = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DEPTH*DATA_WIDTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DEPTH*DATA_WIDTH-1:0] out_data,
  output logic                        out_last
);

  localparam int CW = $clog2(INPUT_W);
  localparam int RW = $clog2(INPUT_H);
  localparam int HW = INPUT_W / 2;
  localparam int AW = (HW > 1) ? $clog2(HW) : 1;
  localparam int PW = DATA_WIDTH + 1;
  localparam int SW = DATA_WIDTH + 2;

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  modeLat;
  logic [DATA_WIDTH-1:0] hold    [DEPTH];
  logic [PW-1:0]         lineBuf [HW][DEPTH];
  logic [PW-1:0]         part    [DEPTH];
  logic [DATA_WIDTH-1:0] res     [DEPTH];

  logic          inXfer;
  logic          colOdd;
  logic          rowOdd;
  logic          lastCol;
  logic          lastRow;
  logic [AW-1:0] lbIdx;

  assign in_ready = !out_valid || out_ready;
  assign inXfer   = in_valid && in_ready;
  assign colOdd   = col[0];
  assign rowOdd   = row[0];
  assign lastCol  = (col == CW'(INPUT_W - 1));
  assign lastRow  = (row == RW'(INPUT_H - 1));
  assign lbIdx    = AW'(col >> 1);

  // Partials keep one guard bit so the 4-sample sum fits in SW bits.
  for (genvar c = 0; c < DEPTH; c++) begin : gCh
    logic signed [DATA_WIDTH-1:0] cur;
    logic signed [DATA_WIDTH-1:0] hd;
    logic signed [PW-1:0]         hSum;
    logic signed [PW-1:0]         hMax;
    logic signed [PW-1:0]         lb;
    logic signed [PW-1:0]         vMax;
    logic signed [SW-1:0]         total;

    assign cur   = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    assign hd    = hold[c];
    assign hSum  = {cur[DATA_WIDTH-1], cur} + {hd[DATA_WIDTH-1], hd};
    assign hMax  = (cur > hd) ? {cur[DATA_WIDTH-1], cur}
                              : {hd[DATA_WIDTH-1], hd};
    assign part[c] = modeLat ? hMax : hSum;
    assign lb    = lineBuf[lbIdx][c];
    assign vMax  = (lb > hMax) ? lb : hMax;
    assign total = {lb[PW-1], lb} + {hSum[PW-1], hSum};
    assign res[c] = modeLat ? DATA_WIDTH'(vMax)
                            : DATA_WIDTH'(total >>> 2);
  end

  always_ff @(posedge clk) begin
    if (inXfer && colOdd && !rowOdd) begin
      for (int c = 0; c < DEPTH; c++) begin
        lineBuf[lbIdx][c] <= part[c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      modeLat   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int c = 0; c < DEPTH; c++) begin
        hold[c] <= '0;
      end
    end else begin
      if (inXfer) begin
        if (col == '0 && row == '0) begin
          modeLat <= mode;
        end
        if (!colOdd) begin
          for (int c = 0; c < DEPTH; c++) begin
            hold[c] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
        if (lastCol) begin
          col <= '0;
          row <= lastRow ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (inXfer && colOdd && rowOdd) begin
        out_valid <= 1'b1;
        out_last  <= lastRow && lastCol;
        for (int c = 0; c < DEPTH; c++) begin
          out_data[c*DATA_WIDTH +: DATA_WIDTH] <= res[c];
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream: 4x4 frames, 3 channels, 16-bit samples.
// Expected pooled values are hand-computed tables.
module tb_pool2x2_stream;

  localparam int DW = 16;
  localparam int D  = 3;

  localparam int EA0 [4] = '{2, 4, 10, 12};
  localparam int EA1 [4] = '{-3, -5, -11, -13};
  localparam int EA2 [4] = '{40, 72, 168, 200};
  localparam int EM0 [4] = '{5, 7, 13, 15};
  localparam int EM1 [4] = '{0, -2, -8, -10};
  localparam int EM2 [4] = '{80, 112, 208, 240};
  localparam int EEA [4] = '{-3, -32768, 32767, 0};
  localparam int EEM [4] = '{-1, -32768, 32767, 0};

  logic          clk;
  logic          reset;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [D*DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [D*DW-1:0] out_data;
  logic          out_last;

  int nChecks = 0;
  int nPass   = 0;

  logic [D*DW-1:0] gotQ  [$];
  logic            lastQ [$];

  pool2x2_stream #(
    .DATA_WIDTH(DW),
    .INPUT_H(4),
    .INPUT_W(4),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mode(mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      gotQ.push_back(out_data);
      lastQ.push_back(out_last);
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [D*DW-1:0] pk(int a0, int a1, int a2);
    return {a2[15:0], a1[15:0], a0[15:0]};
  endfunction

  function automatic logic [D*DW-1:0] inVal(int kind, int p);
    int v;
    if (kind == 0) return pk(p, -p, 16 * p);
    case (p)
      0: v = -1;
      1: v = -2;
      4: v = -3;
      5: v = -4;
      2, 3, 6, 7: v = -32768;
      8, 9, 12, 13: v = 32767;
      default: v = 0;
    endcase
    return pk(v, v, v);
  endfunction

  function automatic logic [D*DW-1:0] expVal(int kind, logic m, int b);
    if (kind == 0) begin
      if (m) return pk(EM0[b], EM1[b], EM2[b]);
      return pk(EA0[b], EA1[b], EA2[b]);
    end
    if (m) return pk(EEM[b], EEM[b], EEM[b]);
    return pk(EEA[b], EEA[b], EEA[b]);
  endfunction

  function automatic logic completes(int p);
    return ((p / 4) % 2 == 1) && (p % 2 == 1);
  endfunction

  task automatic sendBeat(input logic [D*DW-1:0] d, input logic m);
    int n;
    logic acc;
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 40) begin
        check("in_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Mode is only honoured on pixel 0; later beats drive the opposite value.
  task automatic sendFrame(input int kind, input logic m,
                           input int first, input int lastP);
    for (int p = first; p <= lastP; p++) begin
      sendBeat(inVal(kind, p), (p == 0) ? m : ~m);
      check($sformatf("lat_p%0d", p), out_valid, completes(p));
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input int kind, input logic m);
    logic [D*DW-1:0] d;
    logic l;
    for (int b = 0; b < 4; b++) begin
      if (gotQ.size() == 0) begin
        check($sformatf("%s_missing%0d", tag, b), 0, 1);
      end else begin
        d = gotQ.pop_front();
        l = lastQ.pop_front();
        check($sformatf("%s_d%0d", tag, b), d, expVal(kind, m, b));
        check($sformatf("%s_last%0d", tag, b), l, (b == 3));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;
    #3 reset  = 1'b0;
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_rdy", in_ready, 1);

    sendFrame(0, 1'b0, 0, 15);
    idle();
    check("avg_cnt", gotQ.size(), 4);
    checkOut("avg", 0, 1'b0);

    sendFrame(0, 1'b1, 0, 15);
    idle();
    check("max_cnt", gotQ.size(), 4);
    checkOut("max", 0, 1'b1);

    sendFrame(1, 1'b0, 0, 15);
    idle();
    check("eavg_cnt", gotQ.size(), 4);
    checkOut("eavg", 1, 1'b0);

    sendFrame(1, 1'b1, 0, 15);
    idle();
    check("emax_cnt", gotQ.size(), 4);
    checkOut("emax", 1, 1'b1);

    out_ready = 1'b0;
    sendFrame(0, 1'b0, 0, 5);
    in_data  = inVal(0, 6);
    mode     = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_rdy", in_ready, 0);
      check("bp_vld", out_valid, 1);
      check("bp_data", out_data, expVal(0, 1'b0, 0));
      check("bp_last", out_last, 0);
    end
    out_ready = 1'b1;
    sendFrame(0, 1'b0, 6, 15);
    sendFrame(0, 1'b1, 0, 15);
    sendFrame(1, 1'b0, 0, 15);
    idle();
    check("b2b_cnt", gotQ.size(), 12);
    checkOut("bp_avg", 0, 1'b0);
    checkOut("b2b_max", 0, 1'b1);
    checkOut("b2b_eavg", 1, 1'b0);

    sendFrame(0, 1'b0, 0, 4);
    out_ready = 1'b0;
    sendFrame(0, 1'b0, 5, 5);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check("mrst_vld", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_last", out_last, 0);
    @(posedge clk);
    #1;
    check("mrst_vld2", out_valid, 0);
    reset     = 1'b1;
    out_ready = 1'b1;
    gotQ.delete();
    lastQ.delete();
    sendFrame(0, 1'b1, 0, 15);
    idle();
    idle();
    check("post_cnt", gotQ.size(), 4);
    checkOut("post", 0, 1'b1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
